sid_mixer: RTL and testbench



---
 rtl/sid_mixer_pkg.sv | 40 ++++
 rtl/sid_mixer_regs.sv | 74 +++++++
 rtl/sid_mixer.sv | 180 ++++++++++++++++++
 tb/tb_sid_mixer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sid_mixer_pkg.sv
// Shared constants, sequence state encoding and saturation helper for the SID mixer.
package sid_pkg;

    localparam logic [4:0] SID_ADDR_ROUTE   = 5'h17;
    localparam logic [4:0] SID_ADDR_MODEVOL = 5'h18;

    // Positions within the 4-bit mode field (register 0x18 bits 7:4).
    localparam int MODE_LP   = 0;
    localparam int MODE_BP   = 1;
    localparam int MODE_HP   = 2;
    localparam int MODE_3OFF = 3;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_ACC0 = 4'd1,
        ST_ACC1 = 4'd2,
        ST_ACC2 = 4'd3,
        ST_ACC3 = 4'd4,
        ST_FILT = 4'd5,
        ST_SAT  = 4'd6,
        ST_VOL0 = 4'd7,
        ST_VOL1 = 4'd8,
        ST_VOL2 = 4'd9,
        ST_VOL3 = 4'd10,
        ST_OUT  = 4'd11
    } state_t;

    function automatic logic [15:0] sat16(input logic signed [23:0] x);
        logic [15:0] r;
        if (x > 24'sd32767) begin
            r = 16'h7FFF;
        end else if (x < -24'sd32768) begin
            r = 16'h8000;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sid_mixer_regs.sv
// Register decode for route/mode/volume and the per-sequence snapshot of
// registers and audio inputs taken when a sequence starts.
module sid_mixer_regs
    import sid_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             we_i,
    input  logic [4:0]       addr_i,
    input  logic [7:0]       data_i,
    input  logic [15:0]      v1_i,
    input  logic [15:0]      v2_i,
    input  logic [15:0]      v3_i,
    input  logic [15:0]      ext_i,
    input  logic [15:0]      lp_i,
    input  logic [15:0]      bp_i,
    input  logic [15:0]      hp_i,
    output logic [3:0]       route_o,
    output logic [3:0]       mode_o,
    output logic [3:0]       vol_o,
    output logic [3:0][15:0] src_o,
    output logic [2:0][15:0] filt_o
);

    logic [3:0]       route_q;
    logic [3:0]       mode_q;
    logic [3:0]       vol_q;
    logic [3:0]       snap_route_q;
    logic [3:0]       snap_mode_q;
    logic [3:0]       snap_vol_q;
    logic [3:0][15:0] snap_src_q;
    logic [2:0][15:0] snap_filt_q;

    // Live register writes plus the snapshot the datapath works from.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            route_q      <= 4'd0;
            mode_q       <= 4'd0;
            vol_q        <= 4'd0;
            snap_route_q <= 4'd0;
            snap_mode_q  <= 4'd0;
            snap_vol_q   <= 4'd0;
            snap_src_q   <= {4{16'd0}};
            snap_filt_q  <= {3{16'd0}};
        end else begin
            if (we_i) begin
                case (addr_i)
                    SID_ADDR_ROUTE:   route_q <= data_i[3:0];
                    SID_ADDR_MODEVOL: begin
                        mode_q <= data_i[7:4];
                        vol_q  <= data_i[3:0];
                    end
                    default: ;
                endcase
            end
            // Snapshot sees the pre-write values when a write shares the start edge.
            if (start_i) begin
                snap_route_q <= route_q;
                snap_mode_q  <= mode_q;
                snap_vol_q   <= vol_q;
                snap_src_q   <= {ext_i, v3_i, v2_i, v1_i};
                snap_filt_q  <= {hp_i, bp_i, lp_i};
            end
        end
    end

    assign route_o = snap_route_q;
    assign mode_o  = snap_mode_q;
    assign vol_o   = snap_vol_q;
    assign src_o   = snap_src_q;
    assign filt_o  = snap_filt_q;

endmodule

// File: rtl/sid_mixer.sv
// SID output mixer: builds the filter input and the volume-scaled final mix over
// an 11-cycle sequence. Define SID_MIXER_DIGI_EN to add the volume DC step to oMix.
module sid_mixer
    import sid_pkg::*;
#(
    parameter int unsigned FILT_SHIFT = 1,
    parameter int unsigned MIX_SHIFT  = 0
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               clkEn,
    input  logic signed [15:0] iV1,
    input  logic signed [15:0] iV2,
    input  logic signed [15:0] iV3,
    input  logic signed [15:0] iExt,
    input  logic signed [15:0] iLP,
    input  logic signed [15:0] iBP,
    input  logic signed [15:0] iHP,
    input  logic               iWE,
    input  logic [4:0]         iAddr,
    input  logic [7:0]         iData,
    output logic signed [15:0] oFilterIn,
    output logic signed [15:0] oMix,
    output logic               oValid
);

    state_t             state_q;
    logic signed [17:0] acc_f_q;
    logic signed [18:0] acc_d_q;
    logic signed [15:0] mix_sat_q;
    logic signed [20:0] prod_q;
    logic [15:0]        filt_q;
    logic [15:0]        mix_q;
    logic               valid_q;

    logic               start_s;
    logic [3:0]         snap_route_s;
    logic [3:0]         snap_mode_s;
    logic [3:0]         snap_vol_s;
    logic [3:0][15:0]   snap_src_s;
    logic [2:0][15:0]   snap_filt_s;

    logic [15:0]        src_s;
    logic               route_bit_s;
    logic               gate_s;
    logic signed [17:0] acc_f_d;
    logic signed [18:0] acc_d_d;
    logic signed [18:0] filt_sum_s;
    logic signed [20:0] mix_ext_s;
    logic signed [20:0] addend_s;
    logic signed [17:0] filt_shift_s;
    logic signed [18:0] mix_shift_s;
    logic signed [20:0] prod_shift_s;
    logic signed [23:0] out_s;

    assign start_s = (state_q == ST_IDLE) && clkEn;

    sid_mixer_regs u_regs (
        .clk     (clk),
        .rst_n_i (rstN),
        .start_i (start_s),
        .we_i    (iWE),
        .addr_i  (iAddr),
        .data_i  (iData),
        .v1_i    (iV1),
        .v2_i    (iV2),
        .v3_i    (iV3),
        .ext_i   (iExt),
        .lp_i    (iLP),
        .bp_i    (iBP),
        .hp_i    (iHP),
        .route_o (snap_route_s),
        .mode_o  (snap_mode_s),
        .vol_o   (snap_vol_s),
        .src_o   (snap_src_s),
        .filt_o  (snap_filt_s)
    );

    // Per-state operand selection for the accumulate and shift-add steps.
    always_comb begin
        src_s       = 16'd0;
        route_bit_s = 1'b0;
        gate_s      = 1'b0;
        addend_s    = 21'sd0;
        mix_ext_s   = {{5{mix_sat_q[15]}}, mix_sat_q};
        case (state_q)
            ST_ACC0: begin src_s = snap_src_s[0]; route_bit_s = snap_route_s[0]; gate_s = 1'b1; end
            ST_ACC1: begin src_s = snap_src_s[1]; route_bit_s = snap_route_s[1]; gate_s = 1'b1; end
            ST_ACC2: begin
                src_s       = snap_src_s[2];
                route_bit_s = snap_route_s[2];
                gate_s      = ~snap_mode_s[MODE_3OFF];
            end
            ST_ACC3: begin src_s = snap_src_s[3]; route_bit_s = snap_route_s[3]; gate_s = 1'b1; end
            ST_VOL0: addend_s = snap_vol_s[0] ? mix_ext_s          : 21'sd0;
            ST_VOL1: addend_s = snap_vol_s[1] ? (mix_ext_s <<< 1)  : 21'sd0;
            ST_VOL2: addend_s = snap_vol_s[2] ? (mix_ext_s <<< 2)  : 21'sd0;
            ST_VOL3: addend_s = snap_vol_s[3] ? (mix_ext_s <<< 3)  : 21'sd0;
            default: ;
        endcase
    end

    // Accumulator next values, filter-output sum and output scaling.
    always_comb begin
        acc_f_d = acc_f_q;
        acc_d_d = acc_d_q;
        if (route_bit_s) begin
            acc_f_d = acc_f_q + {{2{src_s[15]}}, src_s};
        end else if (gate_s) begin
            acc_d_d = acc_d_q + {{3{src_s[15]}}, src_s};
        end else begin
            acc_d_d = acc_d_q;
        end
        filt_sum_s = (snap_mode_s[MODE_LP] ? {{3{snap_filt_s[0][15]}}, snap_filt_s[0]} : 19'sd0)
                   + (snap_mode_s[MODE_BP] ? {{3{snap_filt_s[1][15]}}, snap_filt_s[1]} : 19'sd0)
                   + (snap_mode_s[MODE_HP] ? {{3{snap_filt_s[2][15]}}, snap_filt_s[2]} : 19'sd0);
        filt_shift_s = acc_f_q >>> FILT_SHIFT;
        mix_shift_s  = acc_d_q >>> MIX_SHIFT;
        prod_shift_s = prod_q >>> 3'd4;
`ifdef SID_MIXER_DIGI_EN
        out_s = {{3{prod_shift_s[20]}}, prod_shift_s} + {12'd0, snap_vol_s, 8'd0};
`else
        out_s = {{3{prod_shift_s[20]}}, prod_shift_s};
`endif
    end

    // Sequencer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q   <= ST_IDLE;
            acc_f_q   <= 18'sd0;
            acc_d_q   <= 19'sd0;
            mix_sat_q <= 16'sd0;
            prod_q    <= 21'sd0;
            filt_q    <= 16'd0;
            mix_q     <= 16'd0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clkEn) begin
                        acc_f_q <= 18'sd0;
                        acc_d_q <= 19'sd0;
                        state_q <= ST_ACC0;
                    end
                end
                ST_ACC0: begin acc_f_q <= acc_f_d; acc_d_q <= acc_d_d; state_q <= ST_ACC1; end
                ST_ACC1: begin acc_f_q <= acc_f_d; acc_d_q <= acc_d_d; state_q <= ST_ACC2; end
                ST_ACC2: begin acc_f_q <= acc_f_d; acc_d_q <= acc_d_d; state_q <= ST_ACC3; end
                ST_ACC3: begin acc_f_q <= acc_f_d; acc_d_q <= acc_d_d; state_q <= ST_FILT; end
                ST_FILT: begin
                    acc_d_q <= acc_d_q + filt_sum_s;
                    filt_q  <= sat16({{6{filt_shift_s[17]}}, filt_shift_s});
                    state_q <= ST_SAT;
                end
                ST_SAT: begin
                    mix_sat_q <= sat16({{5{mix_shift_s[18]}}, mix_shift_s});
                    prod_q    <= 21'sd0;
                    state_q   <= ST_VOL0;
                end
                ST_VOL0: begin prod_q <= prod_q + addend_s; state_q <= ST_VOL1; end
                ST_VOL1: begin prod_q <= prod_q + addend_s; state_q <= ST_VOL2; end
                ST_VOL2: begin prod_q <= prod_q + addend_s; state_q <= ST_VOL3; end
                ST_VOL3: begin prod_q <= prod_q + addend_s; state_q <= ST_OUT;  end
                ST_OUT: begin
                    mix_q   <= sat16(out_s);
                    valid_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oFilterIn = filt_q;
    assign oMix      = mix_q;
    assign oValid    = valid_q;

endmodule

// File: tb/tb_sid_mixer.sv
// Scoreboard bench for sid_mixer: a bench-side model pushes expected results at
// each sequence start; a monitor pops and compares them on every oValid.
module tb_sid_mixer;

    logic               clk = 1'b0;
    logic               rstN;
    logic               clkEn;
    logic signed [15:0] iV1, iV2, iV3, iExt, iLP, iBP, iHP;
    logic               iWE;
    logic [4:0]         iAddr;
    logic [7:0]         iData;
    logic [15:0]        oFilterIn;
    logic [15:0]        oMix;
    logic               oValid;

    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          n_valid = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  sh_route = 4'd0;
    logic [3:0]  sh_mode  = 4'd0;
    logic [3:0]  sh_vol   = 4'd0;

    sid_mixer #(.FILT_SHIFT(1), .MIX_SHIFT(0)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .clkEn     (clkEn),
        .iV1       (iV1),
        .iV2       (iV2),
        .iV3       (iV3),
        .iExt      (iExt),
        .iLP       (iLP),
        .iBP       (iBP),
        .iHP       (iHP),
        .iWE       (iWE),
        .iAddr     (iAddr),
        .iData     (iData),
        .oFilterIn (oFilterIn),
        .oMix      (oMix),
        .oValid    (oValid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int sat_i(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Returns {expected oFilterIn, expected oMix}.
    function automatic logic [31:0] model(input int v1, input int v2, input int v3, input int ext,
                                          input int lp, input int bp, input int hp,
                                          input logic [3:0] rt, input logic [3:0] md,
                                          input logic [3:0] vl);
        int src[4];
        int acc_f, acc_d, filt, ms, mix;
        logic [15:0] f16, m16;
        src[0] = v1; src[1] = v2; src[2] = v3; src[3] = ext;
        acc_f = 0; acc_d = 0;
        for (int k = 0; k < 4; k++) begin
            if (rt[k]) acc_f += src[k];
            else if (!(k == 2 && md[3])) acc_d += src[k];
        end
        if (md[0]) acc_d += lp;
        if (md[1]) acc_d += bp;
        if (md[2]) acc_d += hp;
        filt = sat_i(acc_f >>> 1);
        ms   = sat_i(acc_d);
        mix  = (ms * int'(vl)) >>> 4;
`ifdef SID_MIXER_DIGI_EN
        mix  = mix + int'(vl) * 256;
`endif
        mix  = sat_i(mix);
        f16 = filt[15:0];
        m16 = mix[15:0];
        return {f16, m16};
    endfunction

    // Scoreboard consumer.
    always @(negedge clk) begin
        logic [31:0] e;
        if (oValid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("mix", {16'd0, oMix}, {16'd0, e[15:0]});
                chk("filter_in", {16'd0, oFilterIn}, {16'd0, e[31:16]});
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        iWE = 1'b1; iAddr = a; iData = d;
        @(posedge clk); #1;
        iWE = 1'b0;
        if (a == 5'h17) sh_route = d[3:0];
        if (a == 5'h18) begin sh_mode = d[7:4]; sh_vol = d[3:0]; end
    endtask

    task automatic set_in(input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] v3,
                          input logic [15:0] ext, input logic [15:0] lp, input logic [15:0] bp,
                          input logic [15:0] hp);
        iV1 = v1; iV2 = v2; iV3 = v3; iExt = ext; iLP = lp; iBP = bp; iHP = hp;
    endtask

    // One full sequence; extra=1 adds a stray clkEn at T+3 and a mid-sequence volume write.
    task automatic run(input bit extra);
        logic [31:0] e;
        logic [15:0] held;
        int          v0;
        e = model(iV1, iV2, iV3, iExt, iLP, iBP, iHP, sh_route, sh_mode, sh_vol);
        v0 = n_valid;
        clkEn = 1'b1;
        @(posedge clk); #1;
        clkEn = 1'b0;
        exp_q.push_back(e);
        set_in(16'h1234, 16'h4321, 16'h0F0F, 16'h7777, 16'h5555, 16'h3333, 16'h1111);
        for (int i = 1; i <= 11; i++) begin
            if (extra && i == 3) clkEn = 1'b1;
            if (extra && i == 4) begin iWE = 1'b1; iAddr = 5'h18; iData = 8'h00; end
            @(posedge clk); #1;
            clkEn = 1'b0;
            iWE = 1'b0;
            if (i == 5)  chk("filter_in_t5", {16'd0, oFilterIn}, {16'd0, e[31:16]});
            if (i == 10) chk("valid_early", {31'd0, oValid}, 32'd0);
            if (i == 11) chk("valid_t11", {31'd0, oValid}, 32'd1);
        end
        if (extra) begin sh_mode = 4'd0; sh_vol = 4'd0; end
        held = oMix;
        repeat (3) @(posedge clk);
        #1;
        chk("valid_once", n_valid - v0, 32'd1);
        chk("mix_hold", {16'd0, oMix}, {16'd0, held});
    endtask

    initial begin
        rstN = 1'b0; clkEn = 1'b0; iWE = 1'b0; iAddr = 5'd0; iData = 8'd0;
        set_in(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_filter_in", {16'd0, oFilterIn}, 32'd0);
        chk("rst_mix", {16'd0, oMix}, 32'd0);
        chk("rst_valid", {31'd0, oValid}, 32'd0);
        rstN = 1'b1;
        @(posedge clk); #1;

        // Direct path
        wr(5'h18, 8'h0F); wr(5'h17, 8'h00);
        set_in(16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        run(1'b0);
        // Filter routing with LP
        wr(5'h17, 8'hF1); wr(5'h18, 8'h1F);
        set_in(16'h2000, 16'h0, 16'h0, 16'h0, 16'h0800, 16'h0, 16'h0);
        run(1'b0);
        // Saturation and sign
        wr(5'h17, 8'h00); wr(5'h18, 8'h0F);
        set_in(16'h7000, 16'h7000, 16'h7000, 16'h0, 16'h0, 16'h0, 16'h0);
        run(1'b0);
        set_in(16'hF000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        run(1'b0);
        // 3OFF, then V3 routed to the filter
        wr(5'h18, 8'h8F);
        set_in(16'h0, 16'h0, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0);
        run(1'b0);
        wr(5'h17, 8'h04);
        set_in(16'h0, 16'h0, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0);
        run(1'b0);
        // Silence at full volume, vol=0, and all filter outputs summed
        wr(5'h17, 8'h00); wr(5'h18, 8'h0F);
        set_in(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        run(1'b0);
        wr(5'h18, 8'h70);
        set_in(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run(1'b0);
        wr(5'h18, 8'h79); wr(5'h17, 8'h08);
        set_in(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        run(1'b0);
        // Stray clkEn at T+3 and mid-sequence write are both ignored by this sequence
        wr(5'h17, 8'h02); wr(5'h18, 8'h2B);
        set_in(16'h0321, 16'h0C00, 16'hFE00, 16'h0100, 16'h0, 16'h0444, 16'h0);
        run(1'b1);

        for (int n = 0; n < 16; n++) begin
            wr(5'h17, 8'($urandom_range(0, 255)));
            wr(5'h18, 8'($urandom_range(0, 255)));
            set_in(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom));
            run(1'b0);
        end

        // Reset at T+6 aborts the sequence
        wr(5'h17, 8'h01); wr(5'h18, 8'h0F);
        set_in(16'h2000, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        begin
            int v0;
            v0 = n_valid;
            clkEn = 1'b1;
            @(posedge clk); #1;
            clkEn = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            chk("abort_filter_pre", {16'd0, oFilterIn}, 32'h1000);
            rstN = 1'b0;
            @(posedge clk); #1;
            rstN = 1'b1;
            sh_route = 4'd0; sh_mode = 4'd0; sh_vol = 4'd0;
            chk("abort_filter_in", {16'd0, oFilterIn}, 32'd0);
            chk("abort_mix", {16'd0, oMix}, 32'd0);
            chk("abort_valid", {31'd0, oValid}, 32'd0);
            repeat (10) @(posedge clk);
            #1;
            chk("abort_no_valid", n_valid - v0, 32'd0);
        end
        // Registers cleared by reset: a sequence now yields silence
        set_in(16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        run(1'b0);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
